// File: rtl/ctl_pkg.sv
// Shared definitions for the control-register bank: CR indices, SR bit
// positions, the SR reset value and the exception sequencer state encoding.
package ctl_pkg;

    localparam int CR_SR    = 0;
    localparam int CR_GBR   = 1;
    localparam int CR_VBR   = 2;
    localparam int CR_SSR   = 3;
    localparam int CR_SPC   = 4;
    localparam int CR_PC    = 5;
    localparam int CR_PR    = 6;
    localparam int CR_SGR   = 7;
    localparam int CR_MACH  = 8;
    localparam int CR_MACL  = 9;
    localparam int CR_FPUL  = 10;
    localparam int CR_FPSCR = 11;

    localparam int SR_MD = 30;
    localparam int SR_RB = 29;
    localparam int SR_BL = 28;

    // MD=1, RB=1, BL=1, IMASK=F
    localparam logic [31:0] SR_RESET = 32'h7000_00F0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_VECTOR  = 2'd2,
        ST_RESTORE = 2'd3
    } ctl_state_e;

endpackage

// File: rtl/ctl_exc_fsm.sv
// Exception entry / RTE sequencer. Holds the sequencing state and decodes the
// save, vector and restore enables that the register bank acts on, plus the
// pipeline stall and the exception acknowledge pulse.
import ctl_pkg::*;

module ctl_exc_fsm (
    input  logic clock,
    input  logic reset,
    input  logic exc_req,
    input  logic sr_bl,
    input  logic rte_req,
    output logic idle,
    output logic save_en,
    output logic vector_en,
    output logic restore_en,
    output logic exc_ack,
    output logic busy
);

    ctl_state_e state_q;
    ctl_state_e state_d;

    // State register; an asynchronous reset abandons any sequence in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and output decode; an accepted exception outranks an RTE.
    always_comb begin
        state_d    = state_q;
        idle       = 1'b0;
        save_en    = 1'b0;
        vector_en  = 1'b0;
        restore_en = 1'b0;
        exc_ack    = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (exc_req && !sr_bl) begin
                    state_d = ST_SAVE;
                end else if (rte_req) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_SAVE: begin
                busy    = 1'b1;
                save_en = 1'b1;
                state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                busy      = 1'b1;
                vector_en = 1'b1;
                exc_ack   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RESTORE: begin
                busy       = 1'b1;
                restore_en = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ctl_reg_file.sv
// Control-register bank for the BJX1 pipeline: two ID-stage read ports with
// same-cycle EX write forwarding, one EX write port, and exception entry /
// RTE sequencing through ctl_exc_fsm.
// Optional build macro CTL_MAC64_EN adds an atomic 64-bit {MACH, MACL} write
// port (macWrEn / macWrVal) that overrides wrEn on MACH/MACL.
import ctl_pkg::*;

module ctl_reg_file #(
    parameter int               XLEN     = 32,
    parameter int               NCR      = 16,
    parameter int               IDXW     = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 32'hA000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDXW-1:0]   rdIdxS,
    output logic [XLEN-1:0]   rdValS,
    input  logic [IDXW-1:0]   rdIdxT,
    output logic [XLEN-1:0]   rdValT,
    input  logic              wrEn,
    input  logic [IDXW-1:0]   wrIdx,
    input  logic [XLEN-1:0]   wrVal,
    input  logic [XLEN-1:0]   gprR15,
    input  logic              excReq,
    input  logic [XLEN-1:0]   excOff,
    input  logic              rteReq,
`ifdef CTL_MAC64_EN
    input  logic              macWrEn,
    input  logic [2*XLEN-1:0] macWrVal,
`endif
    output logic              excAck,
    output logic              busy,
    output logic [XLEN-1:0]   srOut,
    output logic [XLEN-1:0]   pcOut
);

    localparam int CRW = $clog2(NCR);

    logic [XLEN-1:0] cr_q [NCR];
    logic [XLEN-1:0] cr_d [NCR];

    logic idle;
    logic save_en;
    logic vector_en;
    logic restore_en;
    logic wr_hit;

    ctl_exc_fsm u_exc_fsm (
        .clock      (clock),
        .reset      (reset),
        .exc_req    (excReq),
        .sr_bl      (cr_q[CR_SR][SR_BL]),
        .rte_req    (rteReq),
        .idle       (idle),
        .save_en    (save_en),
        .vector_en  (vector_en),
        .restore_en (restore_en),
        .exc_ack    (excAck),
        .busy       (busy)
    );

    assign wr_hit = wrEn && idle && (int'(wrIdx) < NCR);

    // Value seen by a read port: out-of-range reads 0, otherwise the stored
    // CR unless a write landing at the coming edge targets the same index.
    function automatic logic [XLEN-1:0] read_cr(input logic [IDXW-1:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (int'(idx) < NCR) begin
            val = cr_q[idx[CRW-1:0]];
            if (wrEn && idle && (wrIdx == idx)) begin
                val = wrVal;
            end
`ifdef CTL_MAC64_EN
            if (macWrEn && idle) begin
                if (idx == IDXW'(CR_MACH)) begin
                    val = macWrVal[2*XLEN-1:XLEN];
                end else if (idx == IDXW'(CR_MACL)) begin
                    val = macWrVal[XLEN-1:0];
                end
            end
`endif
        end
        return val;
    endfunction

    // Forwarding read ports.
    always_comb begin
        rdValS = read_cr(rdIdxS);
        rdValT = read_cr(rdIdxT);
    end

    // Next CR contents: pipeline writes only while idle, sequencer updates otherwise.
    always_comb begin
        for (int i = 0; i < NCR; i++) begin
            cr_d[i] = cr_q[i];
        end
        if (wr_hit) begin
            cr_d[wrIdx[CRW-1:0]] = wrVal;
        end
`ifdef CTL_MAC64_EN
        if (macWrEn && idle) begin
            cr_d[CR_MACH] = macWrVal[2*XLEN-1:XLEN];
            cr_d[CR_MACL] = macWrVal[XLEN-1:0];
        end
`endif
        if (save_en) begin
            cr_d[CR_SSR]        = cr_q[CR_SR];
            cr_d[CR_SPC]        = cr_q[CR_PC];
            cr_d[CR_SGR]        = gprR15;
            cr_d[CR_SR][SR_MD]  = 1'b1;
            cr_d[CR_SR][SR_RB]  = 1'b1;
            cr_d[CR_SR][SR_BL]  = 1'b1;
        end
        if (vector_en) begin
            cr_d[CR_PC] = cr_q[CR_VBR] + excOff;
        end
        if (restore_en) begin
            cr_d[CR_SR] = cr_q[CR_SSR];
            cr_d[CR_PC] = cr_q[CR_SPC];
        end
    end

    // CR storage; reset clears everything except SR and PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCR; i++) begin
                cr_q[i] <= '0;
            end
            cr_q[CR_SR] <= XLEN'(SR_RESET);
            cr_q[CR_PC] <= RESET_PC;
        end else begin
            for (int i = 0; i < NCR; i++) begin
                cr_q[i] <= cr_d[i];
            end
        end
    end

    assign srOut = cr_q[CR_SR];
    assign pcOut = cr_q[CR_PC];

endmodule

// File: tb/tb_ctl_reg_file.sv
// Directed self-checking bench for ctl_reg_file. A behavioural model tracks the
// CR contents and the remaining stall cycles of any sequence in progress; a
// compare process checks every output against it on each falling edge, and
// hand-computed literal checks pin the model at key points.
module tb_ctl_reg_file;

    localparam int XLEN = 32;
    localparam int NCR  = 16;
    localparam int IDXW = 5;

    logic              clock;
    logic              reset;
    logic [IDXW-1:0]   rdIdxS;
    logic [XLEN-1:0]   rdValS;
    logic [IDXW-1:0]   rdIdxT;
    logic [XLEN-1:0]   rdValT;
    logic              wrEn;
    logic [IDXW-1:0]   wrIdx;
    logic [XLEN-1:0]   wrVal;
    logic [XLEN-1:0]   gprR15;
    logic              excReq;
    logic [XLEN-1:0]   excOff;
    logic              rteReq;
`ifdef CTL_MAC64_EN
    logic              macWrEn;
    logic [2*XLEN-1:0] macWrVal;
`endif
    logic              excAck;
    logic              busy;
    logic [XLEN-1:0]   srOut;
    logic [XLEN-1:0]   pcOut;

    int checkCount = 0;
    int passCount  = 0;

    ctl_reg_file #(
        .XLEN     (XLEN),
        .NCR      (NCR),
        .IDXW     (IDXW),
        .RESET_PC (32'hA000_0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rdIdxS   (rdIdxS),
        .rdValS   (rdValS),
        .rdIdxT   (rdIdxT),
        .rdValT   (rdValT),
        .wrEn     (wrEn),
        .wrIdx    (wrIdx),
        .wrVal    (wrVal),
        .gprR15   (gprR15),
        .excReq   (excReq),
        .excOff   (excOff),
        .rteReq   (rteReq),
`ifdef CTL_MAC64_EN
        .macWrEn  (macWrEn),
        .macWrVal (macWrVal),
`endif
        .excAck   (excAck),
        .busy     (busy),
        .srOut    (srOut),
        .pcOut    (pcOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] mCr [16];
    int          mBusyLeft;
    bit          mIsExc;
    bit          mAccept;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [IDXW-1:0] idx);
        if (idx >= 16) return 32'h0;
`ifdef CTL_MAC64_EN
        if (mBusyLeft == 0 && macWrEn && idx == 8) return macWrVal[63:32];
        if (mBusyLeft == 0 && macWrEn && idx == 9) return macWrVal[31:0];
`endif
        if (mBusyLeft == 0 && wrEn && wrIdx == idx) return wrVal;
        return mCr[idx[3:0]];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mCr[i] = 32'h0;
        mCr[0]    = 32'h7000_00F0;
        mCr[5]    = 32'hA000_0000;
        mBusyLeft = 0;
        mIsExc    = 1'b0;
    endtask

    // Model update: idle cycles take writes and start sequences; an exception
    // spends one cycle saving and one vectoring, an RTE one cycle restoring.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            modelReset();
        end else if (mBusyLeft == 0) begin
            mAccept = excReq && !mCr[0][28];
            if (wrEn && wrIdx < 16) mCr[wrIdx[3:0]] = wrVal;
`ifdef CTL_MAC64_EN
            if (macWrEn) begin
                mCr[8] = macWrVal[63:32];
                mCr[9] = macWrVal[31:0];
            end
`endif
            if (mAccept) begin
                mBusyLeft = 2;
                mIsExc    = 1'b1;
            end else if (rteReq) begin
                mBusyLeft = 1;
                mIsExc    = 1'b0;
            end
        end else begin
            if (mIsExc && mBusyLeft == 2) begin
                mCr[3] = mCr[0];
                mCr[4] = mCr[5];
                mCr[7] = gprR15;
                mCr[0][30:28] = 3'b111;
            end else if (mIsExc) begin
                mCr[5] = mCr[2] + excOff;
            end else begin
                mCr[0] = mCr[3];
                mCr[5] = mCr[4];
            end
            mBusyLeft--;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        checkOutput("cmp.rdValS", rdValS, modelRead(rdIdxS));
        checkOutput("cmp.rdValT", rdValT, modelRead(rdIdxT));
        checkOutput("cmp.srOut",  srOut,  mCr[0]);
        checkOutput("cmp.pcOut",  pcOut,  mCr[5]);
        checkOutput("cmp.busy",   {31'b0, busy},   {31'b0, mBusyLeft != 0});
        checkOutput("cmp.excAck", {31'b0, excAck}, {31'b0, mIsExc && mBusyLeft == 1});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [IDXW-1:0] idx, input logic [31:0] val,
                                 input logic exc, input logic [31:0] off, input logic rte);
        wrEn   = we;
        wrIdx  = idx;
        wrVal  = val;
        excReq = exc;
        excOff = off;
        rteReq = rte;
    endtask

    initial begin
        rdIdxS = '0;
        rdIdxT = '0;
        gprR15 = '0;
`ifdef CTL_MAC64_EN
        macWrEn  = 1'b0;
        macWrVal = '0;
`endif
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset state
        rdIdxS = 5'd1;
        rdIdxT = 5'd2;
        atNeg();
        checkOutput("rst.sr",   srOut,  32'h7000_00F0);
        checkOutput("rst.pc",   pcOut,  32'hA000_0000);
        checkOutput("rst.busy", {31'b0, busy}, 32'h0);
        checkOutput("rst.gbr",  rdValS, 32'h0);
        checkOutput("rst.vbr",  rdValT, 32'h0);

        // Write bypass, registered value, out-of-range reads and writes
        tick();
        applyStimulus(1'b1, 5'd1, 32'h1234, 1'b0, 32'h0, 1'b0);
        rdIdxT = 5'd20;
        atNeg();
        checkOutput("wr.bypass", rdValS, 32'h1234);
        checkOutput("rd.oob",    rdValT, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        atNeg();
        checkOutput("wr.stored", rdValS, 32'h1234);
        tick();
        applyStimulus(1'b1, 5'd20, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        rdIdxS = 5'd20;
        atNeg();
        checkOutput("wr.oob", rdValS, 32'h0);
        tick();
        applyStimulus(1'b1, 5'd13, 32'h5A5A_5A5A, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        rdIdxS = 5'd13;
        atNeg();
        checkOutput("wr.spare", rdValS, 32'h5A5A_5A5A);

        // Exception entry: SR=0, VBR=8000_0000, PC=100, R15=FF0, offset 600
        tick();
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd5, 32'h100, 1'b0, 32'h0, 1'b0);
        tick();
        gprR15 = 32'hFF0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h600, 1'b0);
        atNeg();
        checkOutput("exc.busy0", {31'b0, busy}, 32'h0);
        tick();
        atNeg();
        checkOutput("exc.busySave", {31'b0, busy},   32'h1);
        checkOutput("exc.ackSave",  {31'b0, excAck}, 32'h0);
        tick();
        atNeg();
        checkOutput("exc.busyVec", {31'b0, busy},   32'h1);
        checkOutput("exc.ackVec",  {31'b0, excAck}, 32'h1);
        checkOutput("exc.pcOld",   pcOut, 32'h100);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        atNeg();
        checkOutput("exc.busyDone", {31'b0, busy},   32'h0);
        checkOutput("exc.ackDone",  {31'b0, excAck}, 32'h0);
        checkOutput("exc.pcNew",    pcOut, 32'h8000_0600);
        checkOutput("exc.srNew",    srOut, 32'h7000_0000);
        rdIdxS = 5'd3;
        rdIdxT = 5'd4;
        #1;
        checkOutput("exc.ssr", rdValS, 32'h0);
        checkOutput("exc.spc", rdValT, 32'h100);
        rdIdxS = 5'd7;
        #1;
        checkOutput("exc.sgr", rdValS, 32'hFF0);

        // RTE restore
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        atNeg();
        checkOutput("rte.busy", {31'b0, busy}, 32'h1);
        tick();
        atNeg();
        checkOutput("rte.busyDone", {31'b0, busy}, 32'h0);
        checkOutput("rte.sr", srOut, 32'h0);
        checkOutput("rte.pc", pcOut, 32'h100);

        // Blocked exception stays pending until BL clears
        tick();
        applyStimulus(1'b1, 5'd0, 32'h1000_0000, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h600, 1'b0);
        for (int i = 0; i < 5; i++) begin
            atNeg();
            checkOutput("bl.hold", {31'b0, busy}, 32'h0);
            tick();
        end
        checkOutput("bl.pc", pcOut, 32'h100);
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 32'h600, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h4000, 1'b1, 32'h600, 1'b0);
        atNeg();
        checkOutput("bl.stillIdle", {31'b0, busy}, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h600, 1'b0);
        atNeg();
        checkOutput("bl.entered", {31'b0, busy}, 32'h1);
        tick();
        atNeg();
        checkOutput("vbr.ack", {31'b0, excAck}, 32'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        atNeg();
        checkOutput("vbr.pc", pcOut, 32'h4600);
        checkOutput("vbr.sr", srOut, 32'h7000_0000);

        // Asynchronous reset during VECTOR
        tick();
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 32'h600, 1'b0);
        tick();
        tick();
        atNeg();
        checkOutput("arst.inVec", {31'b0, excAck}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("arst.busy", {31'b0, busy},   32'h0);
        checkOutput("arst.ack",  {31'b0, excAck}, 32'h0);
        checkOutput("arst.pc",   pcOut, 32'hA000_0000);
        checkOutput("arst.sr",   srOut, 32'h7000_00F0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        atNeg();
        checkOutput("arst.idle", {31'b0, busy}, 32'h0);

`ifdef CTL_MAC64_EN
        // Atomic MAC write beats a same-cycle MACL write
        tick();
        applyStimulus(1'b1, 5'd9, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        macWrEn  = 1'b1;
        macWrVal = 64'hAAAA_BBBB_CCCC_DDDD;
        rdIdxS   = 5'd8;
        rdIdxT   = 5'd9;
        atNeg();
        checkOutput("mac.bypassH", rdValS, 32'hAAAA_BBBB);
        checkOutput("mac.bypassL", rdValT, 32'hCCCC_DDDD);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        macWrEn = 1'b0;
        atNeg();
        checkOutput("mac.storedH", rdValS, 32'hAAAA_BBBB);
        checkOutput("mac.storedL", rdValT, 32'hCCCC_DDDD);
`endif

        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ctl_reg_file.md
Name: ctl_reg_file

Overview:
Parametrised control-register bank for the BJX1 pipeline. It holds SR/GBR/VBR/SSR/SPC/PC/PR/SGR/MACH/MACL/FPUL/FPSCR plus spare CRs, with two ID-stage read ports and one EX-stage write port.
- Reads forward the same-cycle EX write.
- A small FSM sequences exception entry (save SR/PC/R15, vector through VBR) and RTE restore.
- It raises busy to stall ID/EX while sequencing.

Parameters:
XLEN, 32, control-register width
NCR, 16, number of control registers (≥12; indices ≥12 are general spare CRs)
IDXW, 4, index width (≥ clog2(NCR))
RESET_PC, 32'hA0000000, PC value after reset

Ports:
clock  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
rdIdxS  in  IDXW  read port S index
rdValS  out  XLEN  read port S value (combinational)
rdIdxT  in  IDXW  read port T index
rdValT  out  XLEN  read port T value (combinational)
wrEn  in  1  EX write strobe
wrIdx  in  IDXW  EX write index
wrVal  in  XLEN  EX write data
gprR15  in  XLEN  current R15, captured into SGR on exception entry
excReq  in  1  exception/interrupt request (level, held until excAck)
excOff  in  XLEN  vector offset added to VBR
rteReq  in  1  RTE request (single-cycle pulse)
excAck  out  1  one-cycle pulse when new PC is written on entry
busy  out  1  pipeline stall while FSM is not IDLE
srOut  out  XLEN  registered SR
pcOut  out  XLEN  registered PC (redirect target for IF)

Behaviour:
- Reset (reset=0, async): all CRs 0, except SR=32'h700000F0 (MD=1, RB=1, BL=1, IMASK=F) and PC=RESET_PC. FSM=IDLE, excAck=0, busy=0.
- Reads:
  - rdValX = CR[rdIdxX].
  - If wrEn && state==IDLE && wrIdx==rdIdxX, rdValX = wrVal (bypass).
  - Index ≥ NCR reads 0.
- Writes: in IDLE only, wrEn commits wrVal at the next edge. Index ≥ NCR is ignored. Writes while busy are dropped; the pipeline is stalled by busy, so none are expected.
- FSM states: IDLE, SAVE, VECTOR, RESTORE.
- IDLE → SAVE when excReq && SR[28]==0 (BL clear).
  - The same-cycle wrEn commits first; it belongs to an older instruction.
  - excReq with BL=1 remains pending, with no state change, until BL clears.
- SAVE (1 cycle): SSR<=SR, SPC<=PC, SGR<=gprR15; SR[30:28]<=3'b111 (MD, RB, BL). → VECTOR.
- VECTOR (1 cycle): PC<=VBR+excOff (mod 2^XLEN, wrap ignored); excAck=1. → IDLE.
- RESTORE, entered from IDLE on rteReq (1 cycle): SR<=SSR, PC<=SPC. → IDLE.
- Priority in IDLE: an accepted excReq beats rteReq. rteReq is dropped if lost.
- busy = (state != IDLE), combinational from state.
- Entry latency: excReq sampled at edge N, SAVE during N..N+1, PC visible at edge N+2. busy is high for 2 cycles; RTE holds it for 1 cycle.
- Async reset mid-sequence: returns to IDLE with reset values. No partial save is retained.
- srOut/pcOut are the registered values, never bypassed.

Optional Feature:
CTL_MAC64_EN
- Defined: adds ports macWrEn (in, 1) and macWrVal (in, 2*XLEN). When macWrEn is high in IDLE, {MACH, MACL}<=macWrVal atomically. It overrides wrEn on MACH/MACL in the same cycle, and the read bypass also covers this path.
- Undefined: ports absent; MACH/MACL writable only through wrEn.

Decomposition:
- Shared package (ctl_pkg): CR index constants CR_SR=0, CR_GBR=1, CR_VBR=2, CR_SSR=3, CR_SPC=4, CR_PC=5, CR_PR=6, CR_SGR=7, CR_MACH=8, CR_MACL=9, CR_FPUL=10, CR_FPSCR=11.
- Also in ctl_pkg: SR bit positions (SR_MD=30, SR_RB=29, SR_BL=28), the FSM state encoding and the SR reset constant.
- One sub-module, ctl_exc_fsm: state register plus excAck/busy decode, driving save/vector/restore enables into the bank.

Test Plan:
- Release reset → SR=32'h700000F0, PC=RESET_PC, VBR=0, busy=0; rdIdxS=CR_GBR → 0.
- wrEn, wrIdx=CR_GBR, wrVal=32'h1234 with rdIdxS=CR_GBR in the same cycle → rdValS=32'h1234 that cycle; next cycle the registered value is 32'h1234. rdIdxT=20 → 0.
- SR=0, VBR=32'h8000_0000, PC=32'h100, R15=32'hFF0, excReq, excOff=32'h600 → after 2 edges: SSR=0, SPC=32'h100, SGR=32'hFF0, SR[30:28]=3'b111, PC=32'h8000_0600. excAck pulses once; busy is high for exactly 2 cycles.
- SR.BL=1, excReq held 5 cycles → no state change. Write SR=0 → entry starts the following cycle.
- After entry, rteReq → 1 cycle later SR=0, PC=32'h100; busy high for 1 cycle.
- wrEn VBR=32'h4000 in the same cycle excReq is accepted → vector uses 32'h4000+excOff. Reset pulled low in VECTOR → IDLE, PC=RESET_PC.
- With CTL_MAC64_EN: macWrVal=64'hAAAA_BBBB_CCCC_DDDD → MACH=32'hAAAABBBB, MACL=32'hCCCCDDDD; a same-cycle wrEn to MACL loses.
